// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction controller: FSM states, status codes,
// menu op codes and the BCD digit clamp used by the serial converter.
package atm_pkg;

  typedef enum logic [2:0] {
    S_PIN    = 3'd0,
    S_MENU   = 3'd1,
    S_AMOUNT = 3'd2,
    S_CONV   = 3'd3,
    S_APPLY  = 3'd4,
    S_LOCKED = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    STAT_NONE    = 3'd0,
    STAT_OK      = 3'd1,
    STAT_BAD_PIN = 3'd2,
    STAT_BAD_OP  = 3'd3,
    STAT_FUNDS   = 3'd4,
    STAT_OVF     = 3'd5,
    STAT_LIMIT   = 3'd6,
    STAT_LOCKED  = 3'd7
  } status_e;

  localparam logic [3:0] OP_BAL = 4'd1;
  localparam logic [3:0] OP_DEP = 4'd2;
  localparam logic [3:0] OP_WD  = 4'd3;
  localparam logic [3:0] OP_OUT = 4'd4;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter: MSD first, acc = acc*10 + digit, one digit
// per cycle for N_DIGITS cycles after start. done marks the last digit cycle.
module bcd_to_bin_serial
  import atm_pkg::*;
#(
  parameter int unsigned N_DIGITS = 6,
  parameter int unsigned ACC_W    = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] digits,
  output logic                  done,
  output logic [ACC_W-1:0]      value
);

  localparam int unsigned CNT_W = $clog2(N_DIGITS + 1);

  logic [4*N_DIGITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [ACC_W-1:0]      r_acc;
  logic [3:0]            w_digit;

  assign w_digit = bcd_clamp(r_shift[4*N_DIGITS-1 -: 4]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (start) begin
      r_shift <= digits;
      r_cnt   <= CNT_W'(N_DIGITS);
      r_acc   <= '0;
    end else if (r_cnt != '0) begin
      r_acc   <= r_acc * ACC_W'(10) + ACC_W'(w_digit);
      r_shift <= r_shift << 4;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // The final digit is folded in on the edge that ends the done cycle,
  // so value is complete from the following cycle on.
  assign done  = (r_cnt == CNT_W'(1));
  assign value = r_acc;

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM transaction controller: PIN check with lockout, menu decode, serial amount
// conversion and balance update. Optional daily withdrawal cap: ATM_DAILY_LIMIT_EN.
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter logic [15:0] PIN        = 16'h1234,
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned AMT_DIGITS = 6,
  parameter int unsigned BAL_W      = 32,
  parameter int unsigned INIT_BAL   = 1000
`ifdef ATM_DAILY_LIMIT_EN
  , parameter int unsigned DAILY_LIM = 500
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      digits_i,
  input  logic             enter_i,
  output logic [BAL_W-1:0] balance_o,
  output logic [2:0]       state_o,
  output logic [2:0]       status_o,
  output logic             busy_o
);

  localparam int unsigned ACC_W = $clog2(10 ** AMT_DIGITS);
  localparam int unsigned EXT_W = BAL_W + 1;

  state_e           r_state, w_state_nxt;
  status_e          r_status, w_status_nxt;
  logic [BAL_W-1:0] r_balance, w_balance_nxt;
  logic [2:0]       r_tries, w_tries_nxt, w_tries_inc;
  logic             r_is_wd, w_is_wd_nxt;
  logic             r_enter_q;
  logic             w_cmd, w_conv_start, w_conv_done;
  logic [ACC_W-1:0] w_conv_value;
  logic [EXT_W-1:0] w_amt, w_sum;
  logic             w_unused_digits;
`ifdef ATM_DAILY_LIMIT_EN
  logic [BAL_W-1:0] r_wd_total, w_wd_total_nxt;
`endif

  assign w_cmd           = enter_i & ~r_enter_q;
  assign w_tries_inc     = r_tries + 3'd1;
  assign w_amt           = EXT_W'(w_conv_value);
  assign w_sum           = {1'b0, r_balance} + w_amt;
  assign w_unused_digits = &{1'b0, digits_i};

  bcd_to_bin_serial #(
    .N_DIGITS (AMT_DIGITS),
    .ACC_W    (ACC_W)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_conv_start),
    .digits (digits_i[4*AMT_DIGITS-1:0]),
    .done   (w_conv_done),
    .value  (w_conv_value)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_status_nxt  = r_status;
    w_balance_nxt = r_balance;
    w_tries_nxt   = r_tries;
    w_is_wd_nxt   = r_is_wd;
    w_conv_start  = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
    w_wd_total_nxt = r_wd_total;
`endif
    unique case (r_state)
      S_PIN: if (w_cmd) begin
        if (digits_i[15:0] == PIN) begin
          w_state_nxt  = S_MENU;
          w_status_nxt = STAT_OK;
          w_tries_nxt  = '0;
        end else begin
          w_tries_nxt  = w_tries_inc;
          w_status_nxt = STAT_BAD_PIN;
          if (w_tries_inc == 3'(MAX_TRIES)) begin
            w_state_nxt  = S_LOCKED;
            w_status_nxt = STAT_LOCKED;
          end
        end
      end
      S_MENU: if (w_cmd) begin
        unique case (digits_i[3:0])
          OP_BAL: w_status_nxt = STAT_OK;
          OP_DEP: begin w_state_nxt = S_AMOUNT; w_is_wd_nxt = 1'b0; end
          OP_WD:  begin w_state_nxt = S_AMOUNT; w_is_wd_nxt = 1'b1; end
          OP_OUT: begin w_state_nxt = S_PIN; w_status_nxt = STAT_NONE; end
          default: w_status_nxt = STAT_BAD_OP;
        endcase
      end
      S_AMOUNT: if (w_cmd) begin
        w_state_nxt  = S_CONV;
        w_conv_start = 1'b1;
      end
      S_CONV: if (w_conv_done) w_state_nxt = S_APPLY;
      S_APPLY: begin
        w_state_nxt = S_MENU;
        if (r_is_wd) begin
          // Insufficient funds is reported ahead of the daily cap.
          if (w_amt > {1'b0, r_balance}) begin
            w_status_nxt = STAT_FUNDS;
`ifdef ATM_DAILY_LIMIT_EN
          end else if (({1'b0, r_wd_total} + w_amt) > EXT_W'(DAILY_LIM)) begin
            w_status_nxt = STAT_LIMIT;
`endif
          end else begin
            w_balance_nxt = r_balance - w_amt[BAL_W-1:0];
            w_status_nxt  = STAT_OK;
`ifdef ATM_DAILY_LIMIT_EN
            w_wd_total_nxt = r_wd_total + w_amt[BAL_W-1:0];
`endif
          end
        end else if (w_sum[BAL_W]) begin
          w_status_nxt = STAT_OVF;
        end else begin
          w_balance_nxt = w_sum[BAL_W-1:0];
          w_status_nxt  = STAT_OK;
        end
      end
      S_LOCKED: ;
      default: w_state_nxt = S_PIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_PIN;
      r_status  <= STAT_NONE;
      r_balance <= BAL_W'(INIT_BAL);
      r_tries   <= '0;
      r_is_wd   <= 1'b0;
      r_enter_q <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
      r_wd_total <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_status  <= w_status_nxt;
      r_balance <= w_balance_nxt;
      r_tries   <= w_tries_nxt;
      r_is_wd   <= w_is_wd_nxt;
      r_enter_q <= enter_i;
`ifdef ATM_DAILY_LIMIT_EN
      r_wd_total <= w_wd_total_nxt;
`endif
    end
  end

  assign balance_o = r_balance;
  assign state_o   = r_state;
  assign status_o  = r_status;
  assign busy_o    = (r_state == S_CONV) || (r_state == S_APPLY);

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Directed bench for atm_txn_ctrl with hand-computed expectations.
// BAL_W is narrowed to 20 so that a second large deposit overflows.
module tb_atm_txn_ctrl;

  localparam int unsigned BAL_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      digits_i;
  logic             enter_i;
  logic [BAL_W-1:0] balance_o;
  logic [2:0]       state_o;
  logic [2:0]       status_o;
  logic             busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_n, lat;

  atm_txn_ctrl #(.BAL_W(BAL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_i  (digits_i),
    .enter_i   (enter_i),
    .balance_o (balance_o),
    .state_o   (state_o),
    .status_o  (status_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [31:0] d, input int hold);
    digits_i = d;
    enter_i  = 1'b1;
    cyc(hold);
    enter_i  = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enter_i = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  // Menu op then amount; counts busy cycles and edges until back in MENU.
  task automatic run_amount(input logic [3:0] op, input logic [31:0] amt, input bit inject,
                            output int busy_cnt, output int edges);
    press({28'h0, op}, 1);
    check("amount_state", state_o, 2);
    digits_i = amt;
    enter_i  = 1'b1;
    cyc(1);
    enter_i  = 1'b0;
    edges    = 1;
    busy_cnt = busy_o ? 1 : 0;
    while (state_o != 3'd1 && edges < 40) begin
      if (inject) begin
        digits_i = 32'h4;
        enter_i  = (edges == 3);
      end
      cyc(1);
      edges++;
      if (busy_o) busy_cnt++;
    end
    enter_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enter_i = 1'b0; digits_i = '0;
    cyc(3);
    check("rst_state", state_o, 0);
    check("rst_status", status_o, 0);
    check("rst_balance", balance_o, 1000);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    cyc(1);

    // Two misses then a hit: tries must clear on success.
    press(32'h1111, 1);
    check("miss1_status", status_o, 2);
    press(32'h1111, 1);
    check("miss2_state", state_o, 0);
    press(32'h1234, 1);
    check("pin_ok_state", state_o, 1);
    check("pin_ok_status", status_o, 1);

    press(32'h1, 1);
    check("query_status", status_o, 1);
    press(32'h7, 1);
    check("bad_op_status", status_o, 3);
    check("bad_op_state", state_o, 1);

    run_amount(4'd3, 32'h0000_1001, 1'b0, busy_n, lat);
    check("funds_status", status_o, 4);
    check("funds_balance", balance_o, 1000);

    // An enter edge during conversion is dropped (would otherwise log out).
    run_amount(4'd3, 32'h0000_0250, 1'b1, busy_n, lat);
    check("wd250_busy", busy_n, 7);
    check("wd250_latency", lat, 8);
    check("wd250_balance", balance_o, 750);
    check("wd250_status", status_o, 1);
    cyc(2);
    check("wd250_state", state_o, 1);

    run_amount(4'd2, 32'h0099_9999, 1'b0, busy_n, lat);
    check("dep1_balance", balance_o, 1000749);
    check("dep1_status", status_o, 1);
    run_amount(4'd2, 32'h0099_9999, 1'b0, busy_n, lat);
    check("dep_ovf_status", status_o, 5);
    check("dep_ovf_balance", balance_o, 1000749);

    // Digits above AMT_DIGITS ignored; F clamps to 9 -> 19.
    run_amount(4'd2, 32'hFF00_001F, 1'b0, busy_n, lat);
    check("clamp_balance", balance_o, 1000768);
    run_amount(4'd3, 32'h0, 1'b0, busy_n, lat);
    check("zero_status", status_o, 1);
    check("zero_balance", balance_o, 1000768);

    press(32'h4, 1);
    check("logout_state", state_o, 0);
    check("logout_status", status_o, 0);
    press(32'h1111, 1);
    press(32'h1111, 1);
    check("tries_cleared_state", state_o, 0);

    do_reset();
    press(32'h1234, 1);
    run_amount(4'd3, 32'h0000_0300, 1'b0, busy_n, lat);
    check("lim_wd1_status", status_o, 1);
    check("lim_wd1_balance", balance_o, 700);
    run_amount(4'd3, 32'h0000_0300, 1'b0, busy_n, lat);
`ifdef ATM_DAILY_LIMIT_EN
    check("lim_wd2_status", status_o, 6);
    check("lim_wd2_balance", balance_o, 700);
`else
    check("lim_wd2_status", status_o, 1);
    check("lim_wd2_balance", balance_o, 400);
`endif
    run_amount(4'd3, 32'h0099_9999, 1'b0, busy_n, lat);
    check("funds_prio_status", status_o, 4);
    run_amount(4'd3, 32'h0000_0400, 1'b0, busy_n, lat);
`ifdef ATM_DAILY_LIMIT_EN
    check("exact_status", status_o, 6);
    check("exact_balance", balance_o, 700);
`else
    check("exact_status", status_o, 1);
    check("exact_balance", balance_o, 0);
`endif

    // Reset in the middle of a conversion.
    do_reset();
    press(32'h1234, 1);
    press(32'h3, 1);
    digits_i = 32'h0000_0100;
    enter_i  = 1'b1;
    cyc(1);
    enter_i  = 1'b0;
    check("midconv_state", state_o, 3);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_state", state_o, 0);
    check("midrst_balance", balance_o, 1000);
    check("midrst_busy", busy_o, 0);
    cyc(10);
    check("midrst_balance_later", balance_o, 1000);

    // Lockout; a held enter counts as one attempt.
    press(32'h1111, 4);
    check("lock1_status", status_o, 2);
    check("lock1_state", state_o, 0);
    press(32'h1111, 1);
    check("lock2_status", status_o, 2);
    press(32'h1111, 1);
    check("lock3_state", state_o, 5);
    check("lock3_status", status_o, 7);
    press(32'h1234, 1);
    check("locked_state", state_o, 5);
    check("locked_status", status_o, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
